// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the core-to-APB master bridge.
package apb_bridge_pkg;

    // Bridge transfer phases.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Default forwarding window: the SoC APB peripheral map bounds.
    localparam logic [31:0] DEF_WIN_START = 32'h1A10_0000;
    localparam logic [31:0] DEF_WIN_END   = 32'h1A11_7FFF;

    // Default watchdog length in ACCESS cycles; 0 disables the watchdog.
    localparam int unsigned DEF_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/apb_master_bridge_watchdog.sv
// Per-transfer watchdog: counts ACCESS cycles without pready and flags
// the cycle on which the limit is reached. Compiles away when disabled.
module apb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic timeout
);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wd
            localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] cnt;

            // Stall counter: cleared at reset and at the start of each transfer.
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    cnt <= '0;
                end else if (inc) begin
                    cnt <= cnt + CW'(1);
                end
            end

            // Fires on the stalled cycle that completes the limit, so the
            // FSM can leave ACCESS at the very next edge.
            assign timeout = inc && (cnt == LAST);
        end else begin : g_nowd
            logic unused_wd;
            assign unused_wd = ^{clk, rst, clr, inc};
            assign timeout   = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// Core req/gnt/rvalid port to single APB transfers. Addresses outside the
// forwarding window are answered locally with an error; stalled slaves are
// cut off by the watchdog.
module apb_master_bridge
    import apb_bridge_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [APB_ADDR_WIDTH-1:0] WIN_START = APB_ADDR_WIDTH'(DEF_WIN_START),
    parameter logic [APB_ADDR_WIDTH-1:0] WIN_END   = APB_ADDR_WIDTH'(DEF_WIN_END)
) (
    input  logic                      clk,
    input  logic                      rst,
    // core side
    input  logic                      req_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    // APB master side
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    output logic                      pwrite_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    apb_state_e                state, state_n;
    logic                      in_win;
    logic                      cap;
    logic                      wd_clr, wd_inc, wd_timeout;
    logic                      rsp_vld, rsp_err;
    logic [APB_DATA_WIDTH-1:0] rsp_data;

    assign in_win = (addr_i >= WIN_START) && (addr_i <= WIN_END);

    apb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wd (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .inc     (wd_inc),
        .timeout (wd_timeout)
    );

    // Next state, APB strobes, grant and the response to register next cycle.
    always_comb begin
        state_n   = state;
        gnt_o     = 1'b0;
        psel_o    = 1'b0;
        penable_o = 1'b0;
        cap       = 1'b0;
        wd_clr    = 1'b0;
        wd_inc    = 1'b0;
        rsp_vld   = 1'b0;
        rsp_err   = 1'b0;
        rsp_data  = '0;
        case (state)
            IDLE: begin
                // Grant is only ever given here, which also covers the
                // rvalid cycle of the previous transfer.
                gnt_o = req_i;
                if (req_i) begin
                    cap = 1'b1;
                    if (in_win) begin
                        state_n = SETUP;
                        wd_clr  = 1'b1;
                    end else begin
                        rsp_vld = 1'b1;
                        rsp_err = 1'b1;
                    end
                end
            end
            SETUP: begin
                psel_o  = 1'b1;
                state_n = ACCESS;
            end
            ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                if (pready_i) begin
                    state_n  = IDLE;
                    rsp_vld  = 1'b1;
                    rsp_err  = pslverr_i;
                    rsp_data = pwrite_o ? '0 : prdata_i;
                end else begin
                    wd_inc = 1'b1;
                    if (wd_timeout) begin
                        state_n = IDLE;
                        rsp_vld = 1'b1;
                        rsp_err = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, held APB request fields and the one-cycle response register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            paddr_o  <= '0;
            pwdata_o <= '0;
            pwrite_o <= 1'b0;
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
        end else begin
            state <= state_n;
            if (cap) begin
                paddr_o  <= addr_i;
                pwdata_o <= wdata_i;
                pwrite_o <= we_i;
            end
            rvalid_o <= rsp_vld;
            err_o    <= rsp_err;
            rdata_o  <= rsp_data;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge with a 4-cycle watchdog.
module tb_apb_master_bridge;

    localparam int          TO  = 4;
    localparam logic [31:0] WS  = 32'h1A10_0000;
    localparam logic [31:0] WE_ = 32'h1A11_7FFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i, we_i, gnt_o, rvalid_o, err_o;
    logic [31:0] addr_i, wdata_i, rdata_o;
    logic [31:0] paddr_o, pwdata_o, prdata_i;
    logic        pwrite_o, psel_o, penable_o, pready_i, pslverr_i;

    int tests = 0;
    int fails = 0;

    // observations from the last transfer
    logic        o_gnt, o_err, o_stable, o_chain_gnt;
    logic [31:0] o_data;
    int          o_psel_cyc, o_pen_cyc, o_rv_cyc, o_nacc;

    // follow-on request issued in the rvalid cycle
    logic        chain;
    logic [31:0] nx_addr, nx_wdata;
    logic        nx_we;

    // expected values
    bit          e_inw;
    int          e_rv, e_nacc;
    logic        e_err;
    logic [31:0] e_data;

    always #5 clk = ~clk;

    apb_master_bridge #(
        .APB_ADDR_WIDTH (32),
        .APB_DATA_WIDTH (32),
        .TIMEOUT_CYCLES (TO),
        .WIN_START      (WS),
        .WIN_END        (WE_)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .addr_i    (addr_i),
        .we_i      (we_i),
        .wdata_i   (wdata_i),
        .gnt_o     (gnt_o),
        .rvalid_o  (rvalid_o),
        .rdata_o   (rdata_o),
        .err_o     (err_o),
        .paddr_o   (paddr_o),
        .pwdata_o  (pwdata_o),
        .pwrite_o  (pwrite_o),
        .psel_o    (psel_o),
        .penable_o (penable_o),
        .prdata_i  (prdata_i),
        .pready_i  (pready_i),
        .pslverr_i (pslverr_i)
    );

    // Reference: outcome of one transfer from the bridge's rules, in cycles
    // counted from the grant cycle (c0).
    task automatic model(input logic [31:0] a, input logic w, input int waits,
                         input logic serr, input logic [31:0] prd);
        e_inw = (a >= WS) && (a <= WE_);
        if (!e_inw) begin
            e_nacc = 0; e_rv = 1; e_err = 1'b1; e_data = 32'h0;
        end else if (waits < TO) begin
            e_nacc = waits + 1; e_rv = 2 + e_nacc; e_err = serr;
            e_data = w ? 32'h0 : prd;
        end else begin
            e_nacc = TO; e_rv = 2 + TO; e_err = 1'b1; e_data = 32'h0;
        end
    endtask

    // Drive one transfer and act as an APB slave that answers after
    // 'waits' stalled ACCESS cycles; records what the bridge did.
    task automatic run_xfer(input bit start, input logic [31:0] a, input logic w,
                            input logic [31:0] wd, input int waits,
                            input logic serr, input logic [31:0] prd);
        int cyc;
        int nacc;
        bit done;
        o_psel_cyc = -1; o_pen_cyc = -1; o_rv_cyc = -1; o_stable = 1'b1;
        o_err = 1'b0; o_data = 32'h0; o_chain_gnt = 1'b0;
        if (start) begin
            @(posedge clk); #1;
            req_i = 1'b1; addr_i = a; we_i = w; wdata_i = wd;
            @(negedge clk);
            o_gnt = gnt_o;
        end
        cyc = 0; nacc = 0; done = 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            req_i = 1'b0; addr_i = $urandom; wdata_i = $urandom; we_i = 1'($urandom);
            if (psel_o && penable_o) begin
                pready_i  = (nacc == waits);
                pslverr_i = (nacc == waits) ? serr : 1'($urandom);
                prdata_i  = (nacc == waits) ? prd : $urandom;
            end else begin
                pready_i = 1'($urandom); pslverr_i = 1'($urandom); prdata_i = $urandom;
            end
            if (chain && rvalid_o) begin
                req_i = 1'b1; addr_i = nx_addr; we_i = nx_we; wdata_i = nx_wdata;
            end
            @(negedge clk);
            if (psel_o && o_psel_cyc < 0) o_psel_cyc = cyc;
            if (penable_o && o_pen_cyc < 0) o_pen_cyc = cyc;
            if (psel_o && (paddr_o !== a || pwdata_o !== wd || pwrite_o !== w)) o_stable = 1'b0;
            if (psel_o && penable_o) nacc++;
            if (rvalid_o) begin
                o_rv_cyc = cyc; o_err = err_o; o_data = rdata_o; o_chain_gnt = gnt_o;
                done = 1;
            end
        end
        o_nacc = nacc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({gnt_o, rvalid_o, err_o, psel_o, penable_o, pwrite_o} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {gnt_o, rvalid_o, err_o, psel_o, penable_o, pwrite_o});
        end
        tests++;
        if ({paddr_o, pwdata_o, rdata_o} !== 96'h0) begin
            fails++;
            $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h want 0", paddr_o, pwdata_o, rdata_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_read_basic();
        run_xfer(1, 32'h1A10_1000, 1'b0, 32'h0, 0, 1'b0, 32'hDEAD_BEEF);
        tests++;
        if (o_gnt !== 1'b1) begin fails++; $display("FAIL rd_gnt: got %b want 1", o_gnt); end
        tests++;
        if (o_psel_cyc != 1) begin fails++; $display("FAIL rd_psel_cyc: got %0d want 1", o_psel_cyc); end
        tests++;
        if (o_pen_cyc != 2) begin fails++; $display("FAIL rd_pen_cyc: got %0d want 2", o_pen_cyc); end
        tests++;
        if (o_rv_cyc != 3) begin fails++; $display("FAIL rd_rv_cyc: got %0d want 3", o_rv_cyc); end
        tests++;
        if ({o_err, o_data} !== {1'b0, 32'hDEAD_BEEF}) begin
            fails++; $display("FAIL rd_rsp: err=%b data=%h want 0/deadbeef", o_err, o_data);
        end
        @(negedge clk);
        tests++;
        if (rvalid_o !== 1'b0) begin fails++; $display("FAIL rd_pulse: rvalid=%b want 0", rvalid_o); end
    endtask

    task automatic test_write_waits();
        run_xfer(1, 32'h1A10_7004, 1'b1, 32'h0000_00A5, 3, 1'b0, 32'h1234_5678);
        tests++;
        if (o_stable !== 1'b1) begin fails++; $display("FAIL wr_stable: got %b want 1", o_stable); end
        tests++;
        if (o_nacc != 4) begin fails++; $display("FAIL wr_nacc: got %0d want 4", o_nacc); end
        tests++;
        if (o_rv_cyc != 6) begin fails++; $display("FAIL wr_rv_cyc: got %0d want 6", o_rv_cyc); end
        tests++;
        if ({o_err, o_data} !== 33'h0) begin
            fails++; $display("FAIL wr_rsp: err=%b data=%h want 0/0", o_err, o_data);
        end
    endtask

    task automatic test_out_of_window();
        run_xfer(1, 32'h1A12_0000, 1'b0, 32'h0, 0, 1'b0, 32'hFFFF_FFFF);
        tests++;
        if (o_gnt !== 1'b1) begin fails++; $display("FAIL oow_gnt: got %b want 1", o_gnt); end
        tests++;
        if (o_psel_cyc != -1) begin fails++; $display("FAIL oow_psel: got %0d want -1", o_psel_cyc); end
        tests++;
        if (o_rv_cyc != 1 || {o_err, o_data} !== {1'b1, 32'h0}) begin
            fails++; $display("FAIL oow_rsp: cyc=%0d err=%b data=%h want 1/1/0", o_rv_cyc, o_err, o_data);
        end
    endtask

    task automatic test_timeout();
        run_xfer(1, 32'h1A10_3000, 1'b0, 32'h0, 1000, 1'b0, 32'h0);
        tests++;
        if (o_nacc != TO) begin fails++; $display("FAIL to_nacc: got %0d want %0d", o_nacc, TO); end
        tests++;
        if (o_rv_cyc != 2 + TO || {o_err, o_data} !== {1'b1, 32'h0}) begin
            fails++; $display("FAIL to_rsp: cyc=%0d err=%b data=%h want %0d/1/0", o_rv_cyc, o_err, o_data, 2 + TO);
        end
        tests++;
        if ({psel_o, penable_o} !== 2'b00) begin
            fails++; $display("FAIL to_drop: psel/penable=%b want 00", {psel_o, penable_o});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd;
        wd = $urandom;
        chain = 1'b1; nx_addr = 32'h1A11_0008; nx_we = 1'b1; nx_wdata = wd;
        run_xfer(1, 32'h1A10_2000, 1'b1, 32'h5555_AAAA, 1, 1'b1, 32'h0);
        chain = 1'b0;
        tests++;
        if (o_err !== 1'b1) begin fails++; $display("FAIL b2b_err1: got %b want 1", o_err); end
        tests++;
        if (o_chain_gnt !== 1'b1) begin fails++; $display("FAIL b2b_gnt: got %b want 1", o_chain_gnt); end
        run_xfer(0, nx_addr, 1'b1, wd, 0, 1'b0, 32'h0);
        tests++;
        if (o_rv_cyc != 3 || o_err !== 1'b0 || o_stable !== 1'b1) begin
            fails++; $display("FAIL b2b_second: cyc=%0d err=%b stable=%b want 3/0/1", o_rv_cyc, o_err, o_stable);
        end
    endtask

    task automatic test_rst_mid();
        @(posedge clk); #1;
        req_i = 1'b1; addr_i = 32'h1A10_4000; we_i = 1'b0; pready_i = 1'b0;
        @(posedge clk); #1;
        req_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if ({psel_o, penable_o} !== 2'b11) begin
            fails++; $display("FAIL rm_access: psel/penable=%b want 11", {psel_o, penable_o});
        end
        @(posedge clk); #1;
        rst = 1'b1; pready_i = 1'b1; pslverr_i = 1'b0; prdata_i = 32'hCAFE_F00D;
        @(posedge clk); #1;
        rst = 1'b0; pready_i = 1'b0;
        @(negedge clk);
        tests++;
        if ({psel_o, penable_o, rvalid_o} !== 3'b000) begin
            fails++; $display("FAIL rm_drop: psel/penable/rvalid=%b want 000", {psel_o, penable_o, rvalid_o});
        end
        @(negedge clk);
        tests++;
        if (rvalid_o !== 1'b0) begin fails++; $display("FAIL rm_norv: rvalid=%b want 0", rvalid_o); end
        run_xfer(1, 32'h1A10_4004, 1'b0, 32'h0, 0, 1'b0, 32'h0BAD_CAFE);
        tests++;
        if (o_rv_cyc != 3 || {o_err, o_data} !== {1'b0, 32'h0BAD_CAFE}) begin
            fails++; $display("FAIL rm_after: cyc=%0d err=%b data=%h want 3/0/0badcafe", o_rv_cyc, o_err, o_data);
        end
    endtask

    task automatic test_random();
        logic [31:0] edges [4];
        logic [31:0] a, wd, prd;
        logic        w, serr;
        int          waits, mode;
        edges[0] = WS; edges[1] = WE_; edges[2] = WS - 1; edges[3] = WE_ + 1;
        for (int i = 0; i < 24; i++) begin
            mode = $urandom_range(0, 5);
            if (mode <= 2)      a = WS + $urandom_range(0, WE_ - WS);
            else if (mode == 3) a = $urandom_range(0, WS - 1);
            else if (mode == 4) a = WE_ + 1 + $urandom_range(0, 32'h00FF_FFFF);
            else                a = edges[$urandom_range(0, 3)];
            w = 1'($urandom); wd = $urandom; prd = $urandom; serr = 1'($urandom);
            waits = $urandom_range(0, 5);
            model(a, w, waits, serr, prd);
            run_xfer(1, a, w, wd, waits, serr, prd);
            tests++;
            if (o_gnt !== 1'b1) begin fails++; $display("FAIL rnd%0d_gnt: got %b want 1", i, o_gnt); end
            tests++;
            if (o_psel_cyc != (e_inw ? 1 : -1)) begin
                fails++; $display("FAIL rnd%0d_psel: got %0d want %0d (a=%h)", i, o_psel_cyc, e_inw ? 1 : -1, a);
            end
            tests++;
            if (o_nacc != e_nacc) begin
                fails++; $display("FAIL rnd%0d_nacc: got %0d want %0d", i, o_nacc, e_nacc);
            end
            tests++;
            if (o_rv_cyc != e_rv) begin
                fails++; $display("FAIL rnd%0d_rvcyc: got %0d want %0d", i, o_rv_cyc, e_rv);
            end
            tests++;
            if ({o_err, o_data} !== {e_err, e_data}) begin
                fails++; $display("FAIL rnd%0d_rsp: err=%b data=%h want %b/%h", i, o_err, o_data, e_err, e_data);
            end
            tests++;
            if (o_stable !== 1'b1) begin fails++; $display("FAIL rnd%0d_stable: got %b want 1", i, o_stable); end
        end
    endtask

    initial begin
        rst = 1'b1; req_i = 1'b0; addr_i = '0; we_i = 1'b0; wdata_i = '0;
        prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0; chain = 1'b0;
        nx_addr = '0; nx_we = 1'b0; nx_wdata = '0; o_gnt = 1'b0;
        test_reset();
        test_read_basic();
        test_write_waits();
        test_out_of_window();
        test_timeout();
        test_back_to_back();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
